// File: rtl/hirose_md_padder_if.sv
// Byte-in / block-out bus of the Hirose MD padder.
// A beat moves on a clock edge where valid && ready; the producer holds data and valid until then.
interface hirose_md_padder_if;
    logic [7:0]  byte_i;
    logic        byte_valid;
    logic        byte_last;
    logic        byte_empty;
    logic        byte_ready;
    logic [63:0] block_o;
    logic        block_valid;
    logic        block_last;
    logic        block_ready;

    modport master (
        output byte_i, byte_valid, byte_last, byte_empty, block_ready,
        input  byte_ready, block_o, block_valid, block_last
    );

    modport slave (
        input  byte_i, byte_valid, byte_last, byte_empty, block_ready,
        output byte_ready, block_o, block_valid, block_last
    );
endinterface

// File: rtl/hirose_md_padder.sv
// Packs a byte stream big-endian into 64-bit blocks with Merkle-Damgard padding.
// HIROSE_PAD_LENGTH_EN appends the 64-bit bit-length block; otherwise 0x80 padding only.
module hirose_md_padder #(
    parameter int LEN_W = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    hirose_md_padder_if.slave       bus,
    output logic                    busy,
    output logic [2:0]              state_dbg
);

    typedef enum logic [2:0] {
        COLLECT    = 3'd0,
        PAD        = 3'd1,
        PAD_FULL   = 3'd2,
        EMIT_DATA  = 3'd3,
        EMIT_FINAL = 3'd4,
        DONE       = 3'd5
`ifdef HIROSE_PAD_LENGTH_EN
        , EMIT_LEN = 3'd6
`endif
    } state_t;

    if (LEN_W < 1 || LEN_W > 64) begin : g_len_w_range
        $error("LEN_W must be in 1..64");
    end

    state_t      state;
    state_t      state_next;
    logic [63:0] block_r;
    logic [2:0]  byte_cnt;
    logic        msg_end;
    logic        byte_ready;
    logic        block_valid;
    logic        block_last;
    logic        byte_fire;
    logic        blk_fire;
    logic [5:0]  lane_lsb;
`ifdef HIROSE_PAD_LENGTH_EN
    logic [LEN_W-1:0] bit_len;
`endif

    assign byte_fire = bus.byte_valid && byte_ready;
    assign blk_fire  = block_valid && bus.block_ready;
    // Lane 0 sits in [63:56], so the LSB of lane n is 8*(7-n).
    assign lane_lsb  = {~byte_cnt, 3'b000};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        byte_ready  = 1'b0;
        block_valid = 1'b0;
        block_last  = 1'b0;
        case (state)
            COLLECT: begin
                byte_ready = !rst;
                if (byte_fire) begin
                    if (bus.byte_last && bus.byte_empty) begin
                        state_next = PAD;
                    end else if (byte_cnt == 3'd7) begin
                        state_next = EMIT_DATA;
                    end else if (bus.byte_last) begin
                        state_next = PAD;
                    end
                end
            end
            PAD:      state_next = EMIT_FINAL;
            PAD_FULL: state_next = EMIT_FINAL;
            EMIT_DATA: begin
                block_valid = 1'b1;
                if (blk_fire) begin
                    state_next = msg_end ? PAD_FULL : COLLECT;
                end
            end
            EMIT_FINAL: begin
                block_valid = 1'b1;
`ifdef HIROSE_PAD_LENGTH_EN
                if (blk_fire) begin
                    state_next = EMIT_LEN;
                end
`else
                block_last = 1'b1;
                if (blk_fire) begin
                    state_next = DONE;
                end
`endif
            end
`ifdef HIROSE_PAD_LENGTH_EN
            EMIT_LEN: begin
                block_valid = 1'b1;
                block_last  = 1'b1;
                if (blk_fire) begin
                    state_next = DONE;
                end
            end
`endif
            DONE:    state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            block_r  <= '0;
            byte_cnt <= '0;
            msg_end  <= 1'b0;
`ifdef HIROSE_PAD_LENGTH_EN
            bit_len  <= '0;
`endif
        end else begin
            case (state)
                COLLECT: begin
                    if (byte_fire) begin
                        msg_end <= bus.byte_last;
                        if (!(bus.byte_last && bus.byte_empty)) begin
                            block_r[lane_lsb +: 8] <= bus.byte_i;
                            byte_cnt <= byte_cnt + 3'd1;
`ifdef HIROSE_PAD_LENGTH_EN
                            bit_len  <= bit_len + LEN_W'(8);
`endif
                        end
                    end
                end
                PAD: begin
                    // Marker at the first free lane, zero fill behind it, earlier lanes kept.
                    for (int i = 0; i < 8; i++) begin
                        if (3'(i) == byte_cnt) begin
                            block_r[8*(7-i) +: 8] <= 8'h80;
                        end else if (3'(i) > byte_cnt) begin
                            block_r[8*(7-i) +: 8] <= 8'h00;
                        end
                    end
                end
                PAD_FULL: block_r <= 64'h8000_0000_0000_0000;
                DONE: begin
                    byte_cnt <= '0;
                    msg_end  <= 1'b0;
`ifdef HIROSE_PAD_LENGTH_EN
                    bit_len  <= '0;
`endif
                end
                default: ;
            endcase
        end
    end

`ifdef HIROSE_PAD_LENGTH_EN
    assign bus.block_o = (state == EMIT_LEN) ? 64'(bit_len) : block_r;
`else
    assign bus.block_o = block_r;
`endif
    assign bus.byte_ready  = byte_ready;
    assign bus.block_valid = block_valid;
    assign bus.block_last  = block_last;
    assign busy            = !(state == COLLECT && byte_cnt == 3'd0);
    assign state_dbg       = state;

endmodule
